// File: rtl/sdram_read_fifo.sv
// Single-clock 32-bit read-data buffer between sdram_read and the Wishbone read path.
// Define SDRAM_RFIFO_FWFT_EN for a first-word fall-through read port; default is registered.
module sdram_read_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_wr,
    input  logic [31:0]           fifo_data,
    output logic                  fifo_full,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CountMax   = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0] FullThresh = (DEPTH_LOG2 + 1)'(Depth - FULL_MARGIN);

    logic [31:0]           mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_acc, wr_acc, mem_we;

    always_comb begin
        rd_acc     = rd_en && (count_q != '0);
        // A full FIFO still accepts a write when a word leaves on the same edge.
        wr_acc     = fifo_wr && ((count_q < CountMax) || rd_acc);
        mem_we     = wr_acc && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (fifo_wr && !wr_acc) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= fifo_data;
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign fifo_full = (count_q >= FullThresh);
    assign overflow  = overflow_q;

`ifdef SDRAM_RFIFO_FWFT_EN
    assign rd_data  = empty ? 32'h0 : mem[rd_ptr_q];
    assign rd_valid = !empty;
`else
    logic [31:0] rd_data_q;
    logic        rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule
